// File: rtl/display_pkg.sv
// display_pkg
// Shared types and helpers for the seven-segment scan path.
//   modo_t    : latched display mode (word, error code, blinking error code)
//   NUM_SEG   : segments per digit
//   SEG_BLANK : active-high "all segments off" pattern
//   MAX_DIG   : widest digit bus sel_slice() accepts
//   sel_slice : extract the 7-bit pattern of one digit from a packed bus
package display_pkg;

  typedef enum logic [1:0] {
    MODO_PALABRA = 2'd0,
    MODO_ERROR   = 2'd1,
    MODO_BLINK   = 2'd2
  } modo_t;

  localparam int NUM_SEG = 7;
  localparam logic [NUM_SEG-1:0] SEG_BLANK = 7'b0;
  localparam int MAX_DIG = 16;

  // Constant-index loop instead of a variable part-select so the select
  // never needs an index wider than the bus.
  function automatic logic [NUM_SEG-1:0] sel_slice(
    input logic [NUM_SEG*MAX_DIG-1:0] bus,
    input int unsigned                idx
  );
    logic [NUM_SEG-1:0] res;
    res = SEG_BLANK;
    for (int unsigned i = 0; i < MAX_DIG; i++) begin
      if (i == idx) res = bus[i*NUM_SEG +: NUM_SEG];
    end
    return res;
  endfunction

endpackage

// File: rtl/module_refresh_tick.sv
// module_refresh_tick
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (counter returns to 0)
//   tick_o : high for the single cycle in which the counter holds DIV-1
module module_refresh_tick #(
  parameter int DIV = 27000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/module_display_scan.sv
// module_display_scan
// Time-multiplexed seven-segment scanner. Each digit slot lasts REFRESH_DIV
// clocks; the display mode is chosen once per frame from the decoder flags
// and the (synchronised) user switch, and the error code blinks on a double
// error with a half-period of BLINK_FRAMES frames.
//   clk, rst_n      : clock, asynchronous active-low reset
//   seg_palabra     : corrected-word patterns, digit i at [7i+6:7i], active-high
//   seg_error       : error/syndrome patterns, same packing
//   swi             : asynchronous switch, 0 = word, 1 = error code
//   error_simple    : decoder corrected a single error
//   error_doble     : decoder saw an uncorrectable double error
//   no_error        : decoder saw a clean word
//   seg_out, an_out : registered segment / one-hot anode drive (ACTIVE_LOW polarity)
//   modo_out        : latched mode, for debug LEDs
module module_display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIG      = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SEG*NUM_DIG-1:0] seg_palabra,
  input  logic [NUM_SEG*NUM_DIG-1:0] seg_error,
  input  logic                       swi,
  input  logic                       error_simple,
  input  logic                       error_doble,
  input  logic                       no_error,
  output logic [NUM_SEG-1:0]         seg_out,
  output logic [NUM_DIG-1:0]         an_out,
  output logic [1:0]                 modo_out
);

  localparam int IW = $clog2(NUM_DIG);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [NUM_SEG-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIG-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic                       swi_meta_q, swi_sync_q;
  logic                       tick;
  logic [IW-1:0]              idx_q, idx_d;
  modo_t                      modo_q, modo_d, next_modo;
  logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
  logic                       phase_q, phase_d;
  logic [NUM_SEG-1:0]         seg_q, seg_d, seg_act;
  logic [NUM_DIG-1:0]         an_q, an_d, an_act, an_onehot;
  logic [1:0]                 modo_out_q, modo_out_d;
  logic [NUM_SEG*MAX_DIG-1:0] pal_ext, err_ext;

  module_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  always_comb begin
    pal_ext = '0;
    err_ext = '0;
    pal_ext[NUM_SEG*NUM_DIG-1:0] = seg_palabra;
    err_ext[NUM_SEG*NUM_DIG-1:0] = seg_error;
  end

  // Double error outranks everything; any decoder verdict outranks the switch.
  always_comb begin
    if (error_doble)                   next_modo = MODO_BLINK;
    else if (error_simple || no_error) next_modo = MODO_PALABRA;
    else if (swi_sync_q)               next_modo = MODO_ERROR;
    else                               next_modo = MODO_PALABRA;
  end

  always_comb begin
    idx_d       = idx_q;
    modo_d      = modo_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    seg_d       = seg_q;
    an_d        = an_q;
    modo_out_d  = modo_out_q;
    seg_act     = SEG_BLANK;
    an_act      = '0;
    an_onehot   = '0;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      // Mode and blink state only move when the scan wraps, so a frame is
      // always drawn in a single mode.
      if (idx_q == IDX_LAST) begin
        modo_d = next_modo;
        if (next_modo == MODO_BLINK) begin
          if (modo_q != MODO_BLINK) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      // Output registers load the pattern for the slot that starts now.
      an_onehot = NUM_DIG'(1) << idx_d;
      case (modo_d)
        MODO_ERROR: begin
          seg_act = sel_slice(err_ext, 32'(idx_d));
          an_act  = an_onehot;
        end
        MODO_BLINK: begin
          if (phase_d) begin
            seg_act = sel_slice(err_ext, 32'(idx_d));
            an_act  = an_onehot;
          end
        end
        default: begin  // PALABRA, and the unused encoding
          seg_act = sel_slice(pal_ext, 32'(idx_d));
          an_act  = an_onehot;
        end
      endcase
      seg_d      = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
      an_d       = (ACTIVE_LOW != 0) ? ~an_act : an_act;
      modo_out_d = modo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swi_meta_q  <= 1'b0;
      swi_sync_q  <= 1'b0;
      idx_q       <= '0;
      modo_q      <= MODO_PALABRA;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      modo_out_q  <= 2'd0;
    end else begin
      swi_meta_q  <= swi;
      swi_sync_q  <= swi_meta_q;
      idx_q       <= idx_d;
      modo_q      <= modo_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      modo_out_q  <= modo_out_d;
    end
  end

  assign seg_out  = seg_q;
  assign an_out   = an_q;
  assign modo_out = modo_out_q;

endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan
// Bench for module_display_scan with NUM_DIG=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// Two instances share all inputs: dut (active-high) and dut_al (active-low).
// The reference model tracks elapsed cycles since reset release and derives
// slot, digit, frame boundaries and blink state arithmetically from them.
module tb_module_display_scan;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7*N-1:0] seg_palabra = '0;
  logic [7*N-1:0] seg_error = '0;
  logic          swi = 1'b0;
  logic          error_simple = 1'b0;
  logic          error_doble = 1'b0;
  logic          no_error = 1'b0;
  logic [6:0]    seg_out, seg_out_al;
  logic [N-1:0]  an_out, an_out_al;
  logic [1:0]    modo_out, modo_out_al;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  module_display_scan #(.NUM_DIG(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .seg_palabra(seg_palabra), .seg_error(seg_error),
    .swi(swi), .error_simple(error_simple), .error_doble(error_doble), .no_error(no_error),
    .seg_out(seg_out), .an_out(an_out), .modo_out(modo_out)
  );

  module_display_scan #(.NUM_DIG(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .seg_palabra(seg_palabra), .seg_error(seg_error),
    .swi(swi), .error_simple(error_simple), .error_doble(error_doble), .no_error(no_error),
    .seg_out(seg_out_al), .an_out(an_out_al), .modo_out(modo_out_al)
  );

  // ---------------- reference model ----------------
  int          m_t;     // clock edges since reset release
  int          m_mode;  // 0 word, 1 error, 2 blink
  int          m_k;     // frame boundaries since blink was entered
  logic        swi_d1, swi_d2;
  logic [7*N-1:0] snap_pal, snap_err;

  function automatic int want_mode();
    if (error_doble) return 2;
    if (error_simple || no_error) return 0;
    return swi_d2 ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_mode <= 0; m_k <= 0; swi_d1 <= 1'b0; swi_d2 <= 1'b0;
    end else begin
      swi_d1 <= swi;
      swi_d2 <= swi_d1;
      m_t    <= m_t + 1;
      if ((m_t + 1) % DIV == 0) begin
        snap_pal <= seg_palabra;
        snap_err <= seg_error;
      end
      if ((m_t + 1) % FRAME == 0) begin
        if (want_mode() == 2) m_k <= (m_mode == 2) ? m_k + 1 : 0;
        m_mode <= want_mode();
      end
    end
  end

  // Expected {modo_out, an_out, seg_out} for the active-high instance.
  function automatic logic [12:0] exp_vec();
    int d;
    logic [6:0] s;
    logic [3:0] a;
    if (!rst_n || m_t < DIV) return 13'b0;
    d = (m_t / DIV) % N;
    if (m_mode == 2 && ((m_k / BF) % 2) != 0) return {2'd2, 11'b0};
    a = 4'(1 << d);
    s = (m_mode == 0) ? 7'(snap_pal >> (7 * d)) : 7'(snap_err >> (7 * d));
    return {2'(m_mode), a, s};
  endfunction

  function automatic logic [12:0] al(input logic [12:0] v);
    return {v[12:11], ~v[10:0]};
  endfunction

  task automatic align(input int ph);
    int guard = 0;
    while ((m_t % FRAME) != ph && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if ((m_t % FRAME) != ph) begin
      n_checks++; n_fail++;
      $display("FAIL align_timeout got=%0d required=%0d", m_t % FRAME, ph);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset_scan();
    logic [3:0] an_tab [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [6:0] sg_tab [4] = '{7'h06, 7'h5B, 7'h4F, 7'h3F};
    logic [3:0] ea;
    logic [6:0] es;
    rst_n = 1'b0;
    error_doble = 0; error_simple = 0; no_error = 1; swi = 0;
    seg_palabra = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    seg_error = 28'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({modo_out, an_out, seg_out} !== 13'b0) begin
      n_fail++; $display("FAIL reset_value got=%h required=%h", {modo_out, an_out, seg_out}, 13'b0);
    end
    n_checks++;
    if ({modo_out_al, an_out_al, seg_out_al} !== {2'b00, 4'hF, 7'h7F}) begin
      n_fail++; $display("FAIL reset_value_al got=%h required=%h", {modo_out_al, an_out_al, seg_out_al}, {2'b00, 4'hF, 7'h7F});
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ea = (c < DIV) ? 4'b0 : an_tab[(c / DIV - 1) % 4];
      es = (c < DIV) ? 7'h00 : sg_tab[(c / DIV - 1) % 4];
      n_checks++;
      if ({modo_out, an_out, seg_out} !== {2'b00, ea, es}) begin
        n_fail++; $display("FAIL scan c=%0d got=%h required=%h", c, {modo_out, an_out, seg_out}, {2'b00, ea, es});
      end
      n_checks++;
      if ({an_out_al, seg_out_al} !== {~ea, ~es}) begin
        n_fail++; $display("FAIL scan_al c=%0d got=%h required=%h", c, {an_out_al, seg_out_al}, {~ea, ~es});
      end
    end
  endtask

  task automatic test_priority();
    align(6);
    no_error = 0; error_doble = 1; error_simple = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_checks++;
      if ({modo_out, an_out, seg_out} !== exp_vec()) begin
        n_fail++; $display("FAIL priority c=%0d got=%h required=%h", c, {modo_out, an_out, seg_out}, exp_vec());
      end
    end
    n_checks++;
    if (modo_out !== 2'd0) begin
      n_fail++; $display("FAIL priority_hold got=%0d required=0", modo_out);
    end
    @(negedge clk);
    n_checks++;
    if ({modo_out, an_out, seg_out} !== {2'd2, 4'b0001, seg_error[6:0]}) begin
      n_fail++; $display("FAIL priority_enter got=%h required=%h", {modo_out, an_out, seg_out}, {2'd2, 4'b0001, seg_error[6:0]});
    end
  endtask

  task automatic test_blink();
    logic lit_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    error_simple = 0;
    for (int f = 1; f <= 4; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        n_checks++;
        if ({modo_out, an_out, seg_out} !== exp_vec()) begin
          n_fail++; $display("FAIL blink f=%0d c=%0d got=%h required=%h", f, c, {modo_out, an_out, seg_out}, exp_vec());
        end
        n_checks++;
        if ({modo_out_al, an_out_al, seg_out_al} !== al(exp_vec())) begin
          n_fail++; $display("FAIL blink_al f=%0d c=%0d got=%h required=%h", f, c, {modo_out_al, an_out_al, seg_out_al}, al(exp_vec()));
        end
      end
      n_checks++;
      if ((an_out != 0) !== lit_tab[f-1]) begin
        n_fail++; $display("FAIL blink_phase f=%0d got=%0b required=%0b", f, an_out != 0, lit_tab[f-1]);
      end
    end
    align(5);
    error_doble = 0; error_simple = 1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      n_checks++;
      if ({modo_out, an_out, seg_out} !== exp_vec()) begin
        n_fail++; $display("FAIL blink_exit c=%0d got=%h required=%h", c, {modo_out, an_out, seg_out}, exp_vec());
      end
    end
    n_checks++;
    if (modo_out !== 2'd0) begin
      n_fail++; $display("FAIL blink_exit_mode got=%0d required=0", modo_out);
    end
  endtask

  task automatic test_switch();
    error_simple = 0; error_doble = 0; no_error = 0; swi = 0;
    for (int ph = 0; ph < 2; ph++) begin
      align(7);
      swi = (ph == 0);
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        n_checks++;
        if ({modo_out, an_out, seg_out} !== exp_vec()) begin
          n_fail++; $display("FAIL switch ph=%0d c=%0d got=%h required=%h", ph, c, {modo_out, an_out, seg_out}, exp_vec());
        end
      end
      n_checks++;
      if (modo_out !== ((ph == 0) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL switch_mode ph=%0d got=%0d required=%0d", ph, modo_out, (ph == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    no_error = 1;
    align(9);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({modo_out, an_out, seg_out} !== 13'b0) begin
      n_fail++; $display("FAIL reset_mid got=%h required=%h", {modo_out, an_out, seg_out}, 13'b0);
    end
    n_checks++;
    if ({an_out_al, seg_out_al} !== 11'h7FF) begin
      n_fail++; $display("FAIL reset_mid_al got=%h required=%h", {an_out_al, seg_out_al}, 11'h7FF);
    end
    test_reset_scan();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_checks++;
      if ({modo_out, an_out, seg_out} !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d got=%h required=%h", c, {modo_out, an_out, seg_out}, exp_vec());
      end
      n_checks++;
      if ({modo_out_al, an_out_al, seg_out_al} !== al(exp_vec())) begin
        n_fail++; $display("FAIL random_al c=%0d got=%h required=%h", c, {modo_out_al, an_out_al, seg_out_al}, al(exp_vec()));
      end
      if ($urandom_range(0, 30) == 0) {error_doble, error_simple, no_error} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) swi = ~swi;
      if ($urandom_range(0, 7) == 0) seg_palabra = 28'($urandom);
      if ($urandom_range(0, 7) == 0) seg_error = 28'($urandom);
    end
  endtask

  initial begin
    test_reset_scan();
    test_priority();
    test_blink();
    test_switch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
